// File: rtl/logic_eval_pkg.sv
// Shared types and constants for the logic_eval_sched round-robin evaluator.
package logic_eval_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEval = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit searching upward from ptr+1, wrapping at NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_any
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_eval_sched.sv
// Shares one e = (~a & ~b) | ~c evaluator between NREQ requesters with round-robin grants.
// Define LOGIC_EVAL_STATS_EN to build the saturating completed-transaction counter.
module logic_eval_sched
  import logic_eval_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_abc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_e,
  output logic              busy,
  output logic [STAT_W-1:0] stat_count
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [2:0]       abc_q, abc_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_e_q, rsp_e_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    abc_d       = abc_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_e_d     = rsp_e_q;
    req_ready   = '0;
    unique case (state_q)
      StIdle: begin
        // The picked bit is always a valid requester, so a grant is a handshake.
        if (!rst && grant_any) begin
          req_ready = grant;
          abc_d     = req_abc[3*grant_id +: 3];
          id_d      = grant_id;
          state_d   = StEval;
        end
      end
      StEval: begin
        rsp_e_d     = (~abc_q[2] & ~abc_q[1]) | ~abc_q[0];
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = id_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= IDW'(NREQ - 1);
      abc_q       <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_e_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      abc_q       <= abc_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_e_q     <= rsp_e_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_e     = rsp_e_q;
  assign busy      = (state_q != StIdle);

`ifdef LOGIC_EVAL_STATS_EN
  logic              rsp_fire;
  logic [STAT_W-1:0] stat_q, stat_d;

  assign rsp_fire = (state_q == StResp) && rsp_ready;

  always_comb begin
    stat_d = stat_q;
    if (rsp_fire && (stat_q != STAT_MAX)) begin
      stat_d = stat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_count = stat_q;
`else
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_logic_eval_sched.sv
// Scoreboard bench for logic_eval_sched: grant/result model in the driver, response checks in a monitor.
module tb_logic_eval_sched;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [11:0] req_abc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic        rsp_e;
  logic        busy;
  logic [15:0] stat_count;

  logic_eval_sched #(
    .NREQ (NREQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_abc    (req_abc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_e      (rsp_e),
    .busy       (busy),
    .stat_count (stat_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    bit          e;
    int unsigned t;
  } exp_t;

  exp_t        q[$];
  exp_t        resp_log[$];
  int          model_ptr = NREQ - 1;
  int unsigned exp_stat = 0;
  int          last_grant = -1;
  int          n_pass = 0;
  int          n_checks = 0;
  bit          mon_exp_v;

  function automatic bit ref_eval(input logic [2:0] abc);
    bit a, b, c;
    a = abc[2];
    b = abc[1];
    c = abc[0];
    return (!a && !b) || !c;
  endfunction

  function automatic int model_pick(input logic [3:0] v, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Driver-side model: expected grant, busy, and scoreboard push.
  task automatic check_req();
    int         g;
    logic [3:0] exp_rdy;
    #1;
    last_grant = -1;
    exp_rdy    = '0;
    if (rst) begin
      chk("req_ready_in_reset", {28'd0, req_ready}, 0);
      q.delete();
      model_ptr = NREQ - 1;
      exp_stat  = 0;
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
      g = -1;
      if (q.size() == 0) begin
        g = model_pick(req_valid, model_ptr);
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
      if (g >= 0) begin
        q.push_back('{id: g, e: ref_eval(req_abc[3*g +: 3]), t: cyc});
        last_grant = g;
      end
    end
  endtask

  task automatic tick();
    check_req();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_abc   = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic wait_grant(input int who);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (last_grant != who && n < 30);
    chk("grant_timeout", last_grant, who);
  endtask

  // Monitor: compares every presented response with the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      mon_exp_v = (q.size() != 0) && (cyc >= q[0].t + 2);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, mon_exp_v});
`ifdef LOGIC_EVAL_STATS_EN
      chk("stat_count", {16'd0, stat_count}, exp_stat);
`else
      chk("stat_count", {16'd0, stat_count}, 0);
`endif
      if (mon_exp_v) begin
        chk("rsp_id", {30'd0, rsp_id}, q[0].id);
        chk("rsp_e", {31'd0, rsp_e}, {31'd0, q[0].e});
        if (rsp_ready) begin
          model_ptr = q[0].id;
          resp_log.push_back(q[0]);
          void'(q.pop_front());
          if (exp_stat < 32'hFFFF) exp_stat++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0] tt;
    bit [2:0] v3;
    int       n;
    tt = 8'b0101_0111;
    @(negedge clk);
    do_reset();

    // Truth-table sweep on requester 0.
    resp_log.delete();
    rsp_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      v3        = 3'(v);
      req_valid = 4'b0001;
      req_abc   = {9'd0, v3};
      wait_grant(0);
      req_valid = '0;
      drain();
    end
    chk("sweep_count", resp_log.size(), 8);
    for (int v = 0; v < 8 && v < resp_log.size(); v++) begin
      chk("sweep_e", {31'd0, resp_log[v].e}, {31'd0, tt[v]});
      chk("sweep_id", resp_log[v].id, 0);
    end

    // Round-robin with every requester valid.
    do_reset();
    resp_log.delete();
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    req_abc   = 12'b011_110_000_101;
    n = 0;
    while (resp_log.size() < 5 && n < 60) begin
      tick();
      n++;
    end
    req_valid = '0;
    drain();
    chk("rr_count", resp_log.size() >= 5, 1);
    for (int i = 0; i < 5 && i < resp_log.size(); i++) chk("rr_order", resp_log[i].id, i % NREQ);

    // Back-pressure with competing requesters.
    resp_log.delete();
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    req_abc   = 12'b000_011_000_000;
    wait_grant(2);
    req_valid = 4'b1011;
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    chk("bp_rsp_valid_rise", {31'd0, rsp_valid}, 1);
    repeat (5) tick();
    chk("bp_no_completion", resp_log.size(), 0);
    rsp_ready = 1'b1;
    tick();
    chk("bp_completion", resp_log.size(), 1);
    req_valid = '0;
    drain();

    // Reset pulsed during EVAL.
    req_valid = 4'hF;
    req_abc   = 12'hA5C;
    wait_grant(model_pick(4'hF, model_ptr));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("grant_after_reset", last_grant, 0);
    req_valid = '0;
    drain();

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i]        = 1'b1;
          req_abc[3*i +: 3]   = 3'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    if (last_grant >= 0) req_valid[last_grant] = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();

    // Statistics counter.
    do_reset();
    rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      req_valid = 4'b0100;
      req_abc   = 12'(t) << 6;
      wait_grant(2);
      req_valid = '0;
      drain();
    end
`ifdef LOGIC_EVAL_STATS_EN
    chk("stat_three", {16'd0, stat_count}, 3);
    force dut.stat_q = 16'hFFFE;
    exp_stat = 32'hFFFE;
    tick();
    release dut.stat_q;
`else
    chk("stat_three", {16'd0, stat_count}, 0);
`endif
    for (int t = 0; t < 2; t++) begin
      req_valid = 4'b1000;
      req_abc   = 12'b111 << 9;
      wait_grant(3);
      req_valid = '0;
      drain();
    end
    tick();
`ifdef LOGIC_EVAL_STATS_EN
    chk("stat_saturate", {16'd0, stat_count}, 32'hFFFF);
`else
    chk("stat_saturate", {16'd0, stat_count}, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/logic_eval_sched.md
Name: logic_eval_sched

Overview:
- Round-robin scheduler that shares one 3-input logic evaluator, e = (~a & ~b) | ~c, between NREQ requesters.
- Each requester presents an {a,b,c} operand triple under a valid/ready handshake.
- The scheduler grants one requester, evaluates the triple, and returns the result tagged with the requester index under a second valid/ready handshake.
- Sits between lab stimulus sources (switch decoders, test sequencers) and the display/checker logic.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NREQ), width of the requester index; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i set: requester i presents an operand.
- req_ready  output  NREQ  one-hot grant; a handshake with requester i occurs when req_valid[i] & req_ready[i].
- req_abc  input  3*NREQ  slice [3i+2:3i] = {a,b,c} of requester i.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that produced the result.
- rsp_e  output  1  evaluated result.
- busy  output  1  high in any state other than IDLE.
- stat_count  output  16  completed-transaction count (see Optional Feature).

Behaviour:
- Reset: one clock and one synchronous active-high reset; all state updates on posedge clk. rst=1 forces state=IDLE, ptr=NREQ-1, rsp_valid=0, rsp_id=0, rsp_e=0, stat_count=0.
  - req_ready is 0 while rst=1.
  - Reset mid-transaction discards the in-flight operand and any pending result; no response is emitted.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - If req_valid != 0, grant g = the first set bit searching upward from ptr+1, modulo NREQ.
  - req_ready = one-hot(g), driven combinationally in IDLE only; zero in every other state.
  - On the handshake, capture abc_q = req_abc slice g and id_q = g, then go to EVAL.
  - If req_valid == 0, stay in IDLE with req_ready = 0.
- EVAL (exactly 1 cycle):
  - rsp_e <= (~a & ~b) | ~c computed from abc_q.
  - rsp_id <= id_q; rsp_valid <= 1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_e stable until rsp_ready=1.
  - On the handshake: rsp_valid <= 0, ptr <= id_q, go to IDLE.
- Latency:
  - Request handshake at cycle T gives rsp_valid=1 at T+2.
  - Minimum initiation interval is 3 cycles per transaction (rsp_ready held high).
- Fairness: ptr advances only on response completion. With all requesters valid continuously, grants rotate 0,1,2,...,NREQ-1,0.
- Simultaneous requests: only the round-robin winner sees req_ready; the other requesters must hold req_valid and req_abc stable until granted. A requester dropping req_valid before its grant is not an error.
- Back-pressure: rsp_ready low for any number of cycles stalls in RESP; no new grants are issued meanwhile.
- A single requester, e.g. req_valid=4'b0100 only, is granted regardless of ptr.

Optional Feature:
- Macro: LOGIC_EVAL_STATS_EN.
- Defined: stat_count increments by 1 on each response handshake and saturates at 16'hFFFF; cleared by rst.
- Undefined: stat_count is tied to 16'h0000 and no counter flops are generated.

Decomposition:
- Package logic_eval_pkg holds:
  - the state enum (IDLE=2'd0, EVAL=2'd1, RESP=2'd2);
  - STAT_W=16 and STAT_MAX=16'hFFFF.
- One natural combinational sub-module, rr_pick, maps (req_valid, ptr) to a one-hot grant plus an index.
- The evaluator expression is inlined in EVAL, not a separate module.

Test Plan:
- Reset: rst=1 for 2 cycles, then all inputs 0. Expect req_ready=0, rsp_valid=0, busy=0, stat_count=0.
- Truth-table sweep on requester 0, rsp_ready=1, {a,b,c}=000..111 in order. Expect rsp_e sequence 1,1,1,0,1,0,1,0, rsp_id=0 each time, rsp_valid 2 cycles after each accept.
- Round-robin with NREQ=4: req_valid=4'b1111 held with distinct abc per requester. Expect rsp_id sequence 0,1,2,3,0, exactly one req_ready bit per grant.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid rises. Expect rsp_valid/rsp_id/rsp_e stable, req_ready=0 and busy=1 throughout, and completion on the cycle rsp_ready=1.
- Mid-op reset: rst pulsed during EVAL. Expect no rsp_valid, state IDLE, and the next grant going to requester 0.
- LOGIC_EVAL_STATS_EN defined: run 3 transactions, expect stat_count=3. Force the counter to 16'hFFFE, run 2 more, expect 16'hFFFF. Undefined: expect stat_count=0 after the same sequence.
